// File: rtl/crc32_pkg.sv
// Shared CRC-32 (IEEE 802.3, reflected) constants, FSM state type and step functions.
// Lane 0 of a beat is the first byte on the wire; each byte is consumed LSB first.
package crc32_pkg;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_TAIL, ST_DONE} state_t;

  function automatic logic [31:0] crc32_step8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (CRC32_POLY_REFL & {32{r[0] ^ d[i]}});
    return r;
  endfunction

  function automatic logic [31:0] crc32_step64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = crc32_step8(r, d[8*i +: 8]);
    return r;
  endfunction

  // Number of enabled lanes counted from lane 0 up to the first cleared bit.
  function automatic logic [3:0] keep_len(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run = run & keep[i];
      n   = n + {3'b000, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/crc32_tail_ser.sv
// Byte-serial tail folder: holds the leftover lanes of a partial last beat and
// offers one byte step per cycle; done flags the final byte.
module crc32_tail_ser
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        step,
  input  logic [55:0] load_bytes,
  input  logic [2:0]  load_count,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_next,
  output logic        done
);

  logic [55:0] shift_reg;
  logic [2:0]  count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (load) begin
      shift_reg <= load_bytes;
      count_reg <= load_count;
    end else if (step && count_reg != 3'd0) begin
      shift_reg <= shift_reg >> 8;
      count_reg <= count_reg - 3'd1;
    end
  end

  assign crc_next = crc32_step8(crc_in, shift_reg[7:0]);
  assign done     = (count_reg == 3'd1);

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for the 64-bit CRC-32 datapath: full beats fold in one cycle,
// partial tails fold byte-serially, one FCS pulse per frame. Option: CRC_CHECK_EN adds crc_ok.
module crc32_frame_ctrl
  import crc32_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int CRC_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [7:0]           s_keep,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic                 abort,
  output logic                 crc_valid,
  output logic [CRC_BITS-1:0]  crc_value
`ifdef CRC_CHECK_EN
  ,
  output logic                 crc_ok
`endif
);

  state_t              state;
  logic [CRC_BITS-1:0] crc_reg;
  logic                accept, is_last, full_last, empty_last;
  logic                tail_load, tail_done, fin_now;
  logic [3:0]          tail_len;
  logic [31:0]         word_crc, tail_crc, fin_crc;

  assign accept     = s_valid && s_ready;
  assign tail_len   = keep_len(s_keep);
  assign word_crc   = crc32_step64(crc_reg, s_data);
  assign is_last    = accept && s_last;
  assign full_last  = is_last && tail_len[3];
  assign empty_last = is_last && (tail_len == 4'd0);
  assign tail_load  = is_last && !tail_len[3] && (tail_len != 4'd0) && !abort;

  // The pulse is registered on the edge that enters DONE, so it is visible for the DONE cycle.
  assign fin_now = !abort && ((state == ST_TAIL) ? tail_done : (full_last || empty_last));
  assign fin_crc = (state == ST_TAIL) ? tail_crc : (tail_len[3] ? word_crc : crc_reg);

  crc32_tail_ser u_tail (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tail_load),
    .flush      (abort),
    .step       (state == ST_TAIL),
    .load_bytes (s_data[55:0]),
    .load_count (tail_len[2:0]),
    .crc_in     (crc_reg),
    .crc_next   (tail_crc),
    .done       (tail_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      crc_reg   <= CRC32_INIT;
      s_ready   <= 1'b0;
      crc_valid <= 1'b0;
      crc_value <= '0;
`ifdef CRC_CHECK_EN
      crc_ok    <= 1'b0;
`endif
    end else begin
      crc_valid <= fin_now;
      if (fin_now) begin
        crc_value <= fin_crc ^ CRC32_XOROUT;
`ifdef CRC_CHECK_EN
        crc_ok    <= (fin_crc == CRC32_RESIDUE);
`endif
      end
      if (abort) begin
        state   <= ST_IDLE;
        crc_reg <= CRC32_INIT;
        s_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_BODY: begin
            if (accept && !s_last) begin
              crc_reg <= word_crc;
              state   <= ST_BODY;
            end else if (is_last) begin
              s_ready <= 1'b0;
              if (fin_now) begin
                crc_reg <= fin_crc;
                state   <= ST_DONE;
              end else begin
                state   <= ST_TAIL;
              end
            end else begin
              s_ready <= 1'b1;
            end
          end
          ST_TAIL: begin
            crc_reg <= tail_crc;
            if (tail_done) state <= ST_DONE;
          end
          ST_DONE: begin
            crc_reg <= CRC32_INIT;
            state   <= ST_IDLE;
            s_ready <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/crc32_frame_ctrl.md
# crc32_frame_ctrl

Frame-level sequencer for the 64-bit-parallel CRC-32 datapath. It accepts a stream of 64-bit beats with byte enables and folds each full beat into the CRC in one cycle. Partial tail beats are folded byte-serially, and the block emits the finalized IEEE 802.3 FCS once per frame. It sits between the MAC TX/RX word stream and the FCS insert/strip logic.

## Interface
Parameters:
- DATA_BITS, 64, beat width; fixed at 64 (8 byte lanes).
- CRC_BITS, 32, CRC width; fixed at 32.

Ports:
- clk  in  1  single clock; all logic is on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  64  beat data; lane 0 = s_data[7:0] is the first byte on the wire.
- s_keep  in  8  byte enables; used on the last beat only, contiguous from lane 0.
- s_valid  in  1  beat valid.
- s_last  in  1  final beat of the frame.
- s_ready  out  1  beat accept; a beat transfers when s_valid && s_ready at posedge.
- abort  in  1  discard the current frame.
- crc_valid  out  1  one-cycle pulse carrying the frame result.
- crc_value  out  32  finalized FCS, bit-reflected and XORed with 0xFFFFFFFF.
- crc_ok  out  1  check result; present only with CRC_CHECK_EN.

## Operation
- CRC definition:
  - polynomial 0x04C11DB7, reflected;
  - internal register initialized to 0xFFFFFFFF;
  - final XOR 0xFFFFFFFF.
- FSM states: IDLE, BODY, TAIL, DONE.
- IDLE / BODY:
  - s_ready=1.
  - Accepted beat with s_last=0: 64-bit word step on the register; state becomes BODY.
  - s_keep is ignored on non-last beats; all 8 lanes are used.
- Last beat with s_keep==8'hFF: word step, then go to DONE.
- Last beat with partial s_keep (n = popcount, 0..7):
  - load lanes 0..n-1 into the tail shift register and the byte counter = n;
  - go to TAIL; if n==0, go straight to DONE.
- TAIL:
  - s_ready=0;
  - one byte step per cycle, lowest lane first;
  - counter decrements; go to DONE when it reaches 0.
- DONE:
  - s_ready=0; crc_valid=1 for exactly one cycle;
  - crc_value = ~register;
  - register reloads 0xFFFFFFFF; next state IDLE.
- crc_value holds its value until the next DONE.
- abort:
  - sampled every cycle with priority over beat acceptance;
  - next state IDLE, register reloads 0xFFFFFFFF, no crc_valid.
  - An abort in DONE still lets that cycle's crc_valid pulse complete.
- Non-contiguous s_keep on a last beat: only the lanes below the first zero are used.

## Timing
- Reset values: s_ready=0, crc_valid=0, crc_value=0, crc_ok=0, state IDLE, register 0xFFFFFFFF.
- s_ready is registered and rises on the first posedge after rst_n deasserts.
- Full last beat accepted at edge k: crc_valid is high in cycle k..k+1, and s_ready is high again after edge k+1.
- Partial last beat with n bytes accepted at edge k: TAIL runs for n cycles, then crc_valid is high after edge k+n.
- Throughput: 1 beat per cycle within a frame; 1+n dead cycles per frame.
- An async reset asserted mid-frame immediately forces all reset values; the partial frame is lost and no pulse is emitted.

## Configuration
- CRC_CHECK_EN:
  - Defined: port crc_ok exists. In DONE, crc_ok = (register == 0xDEBB20E3), i.e. crc_value == 0x2144DF1C. It is valid with crc_valid and held until the next DONE.
  - Undefined: no crc_ok port and no compare logic. Generate-only TX use.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY, CRC32_INIT (0xFFFFFFFF), CRC32_XOROUT, CRC32_RESIDUE (0xDEBB20E3);
  - the state enum;
  - pure functions crc32_step64(c, d) and crc32_step8(c, d), both reflected and matching the lane order above.
- One sub-module, crc32_tail_ser: the tail shift register, byte counter and the byte-step path. It reports done to the FSM.

## Test plan
- ASCII "123456789": beat0 = 0x3837363534333231 keep 0xFF; beat1 = 0x39 keep 0x01 last -> one TAIL cycle, crc_valid with crc_value = 0xCBF43926.
- Single beat 0x0000000000000000 keep 0xFF last -> crc_valid one cycle after accept, crc_value = 0x6522DF69.
- With CRC_CHECK_EN, a 13-byte frame: beat0 as above; beat1 = 0x000000CBF4392639 keep 0x1F last -> 5 TAIL cycles, crc_ok = 1. Flip one bit -> crc_ok = 0.
- abort asserted between beat0 and beat1 of the first scenario, then the full first-scenario frame resent -> no pulse for the aborted frame, then crc_value = 0xCBF43926.
- rst_n pulsed low mid-TAIL -> all outputs 0 immediately. After release, s_ready = 1 one edge later, and the next frame gives the correct CRC.
- Back-to-back frames with s_valid held high -> s_ready shows exactly one low cycle between full-last frames, and each frame's CRC is independent.
